// File: rtl/adc_seq_pkg.sv
// Shared types for the ADC sequencer: FSM states, phase strobe vector, bit-index width.
package adc_seq_pkg;

   localparam int NBITS_DEFAULT = 16;
   localparam int IDX_W         = $clog2(NBITS_DEFAULT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SAMP,
      S_COMP,
      S_UPDATE,
      S_DONE
   } seq_state_e;

   typedef struct packed {
      logic init;
      logic samp;
      logic comp;
      logic update;
   } phase_t;

   // One-hot strobe pattern for a state; a gap cycle forces all strobes low.
   function automatic phase_t phase_of(seq_state_e s, logic gap);
      phase_t p;
      p = '0;
      if (!gap) begin
         case (s)
            S_INIT:   p.init   = 1'b1;
            S_SAMP:   p.samp   = 1'b1;
            S_COMP:   p.comp   = 1'b1;
            S_UPDATE: p.update = 1'b1;
            default:  p        = '0;
         endcase
      end
      return p;
   endfunction

endpackage

// File: rtl/seq_phase_cnt.sv
// Loadable down-counter timing each sequencer phase; tc is high while the count is zero.
// Load has priority; the count parks at zero until reloaded.
module seq_phase_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/adc_sequencer.sv
// SAR ADC sequencer: registered init/samp/comp/update strobes, MSB-first word on valid/ready.
// DONE stalls with busy held until the word can be loaded; ADC_SEQ_NONOVERLAP_EN adds a gap cycle per phase change.
module adc_sequencer
   import adc_seq_pkg::*;
#(
   parameter int NBITS         = NBITS_DEFAULT,
   parameter int SAMP_CYCLES   = 4,
   parameter int COMP_CYCLES   = 1,
   parameter int UPDATE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             continuous,
   input  logic             comp_out,
   output logic             seq_init,
   output logic             seq_samp,
   output logic             seq_comp,
   output logic             seq_update,
   output logic             busy,
   output logic [NBITS-1:0] result,
   output logic             result_valid,
   input  logic             result_ready
);

   localparam int IW    = (NBITS == NBITS_DEFAULT) ? IDX_W : $clog2(NBITS);
   localparam int MAX_A = (SAMP_CYCLES > COMP_CYCLES) ? SAMP_CYCLES : COMP_CYCLES;
   localparam int MAXC  = (MAX_A > UPDATE_CYCLES) ? MAX_A : UPDATE_CYCLES;
   localparam int CNT_W = $clog2(MAXC + 1);

   seq_state_e       state_q, state_d, enter_state;
   phase_t           phase_q, phase_d;
   logic             busy_q;
   logic [IW-1:0]    idx_q, idx_d;
   logic [NBITS-1:0] sreg_q, sreg_d;
   logic [NBITS-1:0] result_q, result_d;
   logic             rv_q, rv_d;
   logic             enter;
   logic             cnt_load, tc;
   logic [CNT_W-1:0] cnt_val;
   logic             in_gap;

`ifdef ADC_SEQ_NONOVERLAP_EN
   logic gap_q, gap_d;
   assign in_gap = gap_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gap_q <= 1'b0;
      else        gap_q <= gap_d;
   end
`else
   assign in_gap = 1'b0;
`endif

   function automatic logic [CNT_W-1:0] dur(seq_state_e s);
      case (s)
         S_SAMP:   return CNT_W'(SAMP_CYCLES - 1);
         S_COMP:   return CNT_W'(COMP_CYCLES - 1);
         S_UPDATE: return CNT_W'(UPDATE_CYCLES - 1);
         default:  return '0;
      endcase
   endfunction

   seq_phase_cnt #(.W(CNT_W)) u_phase_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tc       (tc)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sreg_d      = sreg_q;
      result_d    = result_q;
      rv_d        = rv_q;
      cnt_load    = 1'b0;
      cnt_val     = '0;
      enter       = 1'b0;
      enter_state = state_q;
`ifdef ADC_SEQ_NONOVERLAP_EN
      gap_d       = 1'b0;
`endif

      if (rv_q && result_ready) rv_d = 1'b0;

      // During a gap state_q already names the upcoming phase; its timer starts when the gap ends.
      if (in_gap) begin
         cnt_load = tc;
         cnt_val  = dur(state_q);
`ifdef ADC_SEQ_NONOVERLAP_EN
         gap_d    = !tc;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start || continuous) state_d = S_INIT;
            end
            S_INIT: begin
               enter       = 1'b1;
               enter_state = S_SAMP;
            end
            S_SAMP: begin
               if (tc) begin
                  idx_d       = IW'(NBITS - 1);
                  enter       = 1'b1;
                  enter_state = S_COMP;
               end
            end
            S_COMP: begin
               if (tc) begin
                  sreg_d[idx_q] = comp_out;
                  if (idx_q == '0) begin
                     state_d = S_DONE;
                  end else begin
                     enter       = 1'b1;
                     enter_state = S_UPDATE;
                  end
               end
            end
            S_UPDATE: begin
               if (tc) begin
                  idx_d       = idx_q - IW'(1);
                  enter       = 1'b1;
                  enter_state = S_COMP;
               end
            end
            S_DONE: begin
               if (!rv_q || result_ready) begin
                  result_d = sreg_q;
                  rv_d     = 1'b1;
                  state_d  = continuous ? S_INIT : S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (enter) begin
         state_d  = enter_state;
         cnt_load = 1'b1;
`ifdef ADC_SEQ_NONOVERLAP_EN
         gap_d    = 1'b1;
         cnt_val  = '0;
`else
         cnt_val  = dur(enter_state);
`endif
      end

`ifdef ADC_SEQ_NONOVERLAP_EN
      phase_d = phase_of(state_d, gap_d);
`else
      phase_d = phase_of(state_d, 1'b0);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         busy_q   <= 1'b0;
         idx_q    <= '0;
         sreg_q   <= '0;
         result_q <= '0;
         rv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         busy_q   <= (state_d != S_IDLE);
         idx_q    <= idx_d;
         sreg_q   <= sreg_d;
         result_q <= result_d;
         rv_q     <= rv_d;
      end
   end

   assign seq_init     = phase_q.init;
   assign seq_samp     = phase_q.samp;
   assign seq_comp     = phase_q.comp;
   assign seq_update   = phase_q.update;
   assign busy         = busy_q;
   assign result       = result_q;
   assign result_valid = rv_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: timing, data, backpressure, continuous mode and async reset.
module tb_adc_sequencer;

`ifdef ADC_SEQ_NONOVERLAP_EN
   localparam int LAT     = 69;
   localparam int ADJ_EXP = 0;
`else
   localparam int LAT     = 37;
   localparam int ADJ_EXP = 32;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, continuous, comp_out, result_ready;
   logic        seq_init, seq_samp, seq_comp, seq_update, busy, result_valid;
   logic [15:0] result;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int          n_init, n_comp, n_update, adj_trans, onehot_err, comp_idx;
   int          init_cyc[4];
   logic [15:0] pats[4];
   logic [15:0] xfer_q[$];

   adc_sequencer #(
      .NBITS(16), .SAMP_CYCLES(4), .COMP_CYCLES(1), .UPDATE_CYCLES(1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .continuous   (continuous),
      .comp_out     (comp_out),
      .seq_init     (seq_init),
      .seq_samp     (seq_samp),
      .seq_comp     (seq_comp),
      .seq_update   (seq_update),
      .busy         (busy),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Negedge monitor: feeds comparator decisions MSB first and tallies strobes and transfers.
   initial begin
      logic [3:0] ph;
      logic [3:0] prev_ph;
      prev_ph = '0;
      forever begin
         @(negedge clk);
         ph = {seq_init, seq_samp, seq_comp, seq_update};
         if ($countones(ph) > 1) onehot_err++;
         if (ph != 4'b0 && prev_ph != 4'b0 && ph != prev_ph) adj_trans++;
         if (seq_init && !prev_ph[3]) begin
            if (n_init < 4) init_cyc[n_init] = cyc;
            n_init++;
            comp_idx = 0;
         end
         if (seq_comp) begin
            n_comp++;
            if (n_init >= 1 && n_init <= 4 && comp_idx < 16)
               comp_out = pats[n_init-1][15-comp_idx];
            comp_idx++;
         end
         if (seq_update) n_update++;
         if (result_valid && result_ready) xfer_q.push_back(result);
         prev_ph = ph;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      n_init = 0; n_comp = 0; n_update = 0; adj_trans = 0; onehot_err = 0; comp_idx = 0;
      for (int i = 0; i < 4; i++) init_cyc[i] = -1;
      xfer_q.delete();
   endtask

   task automatic wait_rv(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (result_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; continuous = 1'b0; comp_out = 1'b0; result_ready = 1'b0;
      clear_mon();
      tick(3);
      n_checks++;
      if ({seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, result} !== 22'h0)
         $display("FAIL reset_hold: outputs=%h expected 0", {seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, result});
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         n_checks++;
         if ({seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, result} !== 22'h0) begin
            n_fail++;
            $display("FAIL idle_cycle_%0d: outputs=%h expected 0", i, {seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, result});
         end
      end
   endtask

   task automatic test_single();
      bit ok;
      int s_cyc, rv_at;
      clear_mon();
      pats[0] = 16'hA5C3;
      result_ready = 1'b1;
      start = 1'b1;
      s_cyc = cyc;
      tick(1);
      start = 1'b0;
      n_checks++;
      if (seq_init !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_init: seq_init=%b busy=%b expected 1 1", seq_init, busy);
      end
      wait_rv(LAT + 20, ok);
      rv_at = cyc;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL single_timeout: result_valid never rose"); end
      n_checks++;
      if (init_cyc[0] - s_cyc !== 1) begin
         n_fail++;
         $display("FAIL single_start_to_init: got %0d cycles expected 1", init_cyc[0] - s_cyc);
      end
      n_checks++;
      if (rv_at - init_cyc[0] !== LAT) begin
         n_fail++;
         $display("FAIL single_latency: got %0d expected %0d", rv_at - init_cyc[0], LAT);
      end
      n_checks++;
      if (result !== 16'hA5C3) begin n_fail++; $display("FAIL single_result: got %h expected a5c3", result); end
      n_checks++;
      if (n_comp !== 16) begin n_fail++; $display("FAIL single_comp_count: got %0d expected 16", n_comp); end
      n_checks++;
      if (n_update !== 15) begin n_fail++; $display("FAIL single_update_count: got %0d expected 15", n_update); end
      n_checks++;
      if (adj_trans !== ADJ_EXP) begin
         n_fail++;
         $display("FAIL single_phase_gaps: adjacent transitions %0d expected %0d", adj_trans, ADJ_EXP);
      end
      n_checks++;
      if (onehot_err !== 0) begin n_fail++; $display("FAIL single_onehot: %0d multi-strobe cycles expected 0", onehot_err); end
      tick(1);
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_drain: result_valid=%b busy=%b expected 0 0", result_valid, busy);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_mon();
      pats[0] = 16'hA5C3;
      pats[1] = 16'h3C5A;
      result_ready = 1'b0;
      continuous = 1'b1;
      wait_rv(LAT + 20, ok);
      n_checks++;
      if (!ok || result !== 16'hA5C3) begin
         n_fail++;
         $display("FAIL bp_first: valid=%b result=%h expected 1 a5c3", ok, result);
      end
      tick(LAT + 20);
      n_checks++;
      if (busy !== 1'b1 || result_valid !== 1'b1 || result !== 16'hA5C3) begin
         n_fail++;
         $display("FAIL bp_stall: busy=%b valid=%b result=%h expected 1 1 a5c3", busy, result_valid, result);
      end
      n_checks++;
      if (n_init !== 2 || xfer_q.size() !== 0) begin
         n_fail++;
         $display("FAIL bp_no_advance: inits=%0d xfers=%0d expected 2 0", n_init, xfer_q.size());
      end
      continuous = 1'b0;
      result_ready = 1'b1;
      tick(1);
      n_checks++;
      if (result_valid !== 1'b1 || result !== 16'h3C5A) begin
         n_fail++;
         $display("FAIL bp_reload: valid=%b result=%h expected 1 3c5a", result_valid, result);
      end
      tick(1);
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: valid=%b busy=%b expected 0 0", result_valid, busy);
      end
      n_checks++;
      if (xfer_q.size() !== 2 || xfer_q[0] !== 16'hA5C3 || xfer_q[1] !== 16'h3C5A) begin
         n_fail++;
         $display("FAIL bp_order: %0d words first=%h expected 2 words a5c3,3c5a", xfer_q.size(),
                  (xfer_q.size() > 0) ? xfer_q[0] : 16'hxxxx);
      end
   endtask

   task automatic test_continuous();
      bit ok;
      clear_mon();
      pats[0] = 16'h1234; pats[1] = 16'hFEDC; pats[2] = 16'h0F0F;
      result_ready = 1'b1;
      continuous = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 3 * LAT + 50; i++) begin
         tick(1);
         if (n_init == 3) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL cont_third_start: inits=%0d expected 3", n_init); end
      tick(10);
      continuous = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < LAT + 20; i++) begin
         tick(1);
         if (!busy) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL cont_idle_timeout: busy still 1"); end
      tick(LAT + 10);
      n_checks++;
      if (init_cyc[1] - init_cyc[0] !== LAT || init_cyc[2] - init_cyc[1] !== LAT) begin
         n_fail++;
         $display("FAIL cont_period: %0d %0d expected %0d", init_cyc[1] - init_cyc[0], init_cyc[2] - init_cyc[1], LAT);
      end
      n_checks++;
      if (n_init !== 3 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL cont_stop: inits=%0d busy=%b expected 3 0", n_init, busy);
      end
      n_checks++;
      if (xfer_q.size() !== 3) begin
         n_fail++;
         $display("FAIL cont_words: got %0d words expected 3", xfer_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (xfer_q[i] !== pats[i]) begin
               n_fail++;
               $display("FAIL cont_word_%0d: got %h expected %h", i, xfer_q[i], pats[i]);
            end
         end
      end
   endtask

   task automatic test_reset_midop();
      bit ok;
      int base_comp, base_init;
      clear_mon();
      pats[0] = 16'h1111; pats[1] = 16'h5A5A;
      result_ready = 1'b0;
      continuous = 1'b0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_rv(LAT + 20, ok);
      n_checks++;
      if (!ok || result !== 16'h1111) begin
         n_fail++;
         $display("FAIL midop_first: valid=%b result=%h expected 1 1111", ok, result);
      end
      tick(2);
      base_comp = n_comp;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (n_comp == base_comp + 8) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok || seq_comp !== 1'b1 || result_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midop_reach: reached=%b seq_comp=%b valid=%b expected 1 1 1", ok, seq_comp, result_valid);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, result} !== 22'h0) begin
         n_fail++;
         $display("FAIL midop_async: outputs=%h expected 0", {seq_init, seq_samp, seq_comp, seq_update, busy, result_valid, result});
      end
      tick(2);
      rst_n = 1'b1;
      base_init = n_init;
      tick(100);
      n_checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || n_init !== base_init || result !== 16'h0) begin
         n_fail++;
         $display("FAIL midop_after: valid=%b busy=%b new_inits=%0d result=%h expected 0 0 0 0",
                  result_valid, busy, n_init - base_init, result);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_continuous();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
